// File: rtl/viol_detect_pkg.sv
// Shared traffic definitions: light encodings and default timing for the
// red-light violation detector.
package viol_detect_pkg;

  // Light phase encoding carried on every light_* bus.
  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RSVD   = 2'b11
  } light_e;

  // Default timing, all in clk_50 cycles.
  localparam int unsigned PULSE_CYC_DEF    = 8;
  localparam int unsigned HOLDOFF_CYC_DEF  = 16;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1000000;

  // The reserved encoding is treated as red so a corrupted light bus fails safe.
  function automatic logic is_red(logic [1:0] light);
    return (light == RED) || (light == RSVD);
  endfunction

endpackage

// File: rtl/viol_detect_if.sv
// Signal bundle between the intersection controller / sensors and the
// violation detector. master drives lights, sensors and clear; slave is the
// detector.
interface viol_detect_if;

  logic [1:0] light_n;
  logic [1:0] light_s;
  logic [1:0] light_w;
  logic [1:0] light_e;
  logic       car_n;
  logic       car_s;
  logic       car_w;
  logic       car_e;
  logic       count_clr;
  logic       viol_n_50;
  logic       viol_s_50;
  logic       viol_w_50;
  logic       viol_e_50;
  logic       viol_any;
  logic [7:0] viol_count;

  modport master (
    output light_n, light_s, light_w, light_e,
    output car_n, car_s, car_w, car_e,
    output count_clr,
    input  viol_n_50, viol_s_50, viol_w_50, viol_e_50,
    input  viol_any, viol_count
  );

  modport slave (
    input  light_n, light_s, light_w, light_e,
    input  car_n, car_s, car_w, car_e,
    input  count_clr,
    output viol_n_50, viol_s_50, viol_w_50, viol_e_50,
    output viol_any, viol_count
  );

endinterface

// File: rtl/viol_chan.sv
// One approach channel: raw sensor synchronizer, debouncer, rising-edge
// detect and the IDLE -> PULSE -> HOLDOFF pulse stretcher.
module viol_chan
  import viol_detect_pkg::*;
#(
  parameter int unsigned PULSE_CYC    = PULSE_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [1:0] light,
  input  logic       car,
  output logic       accept,
  output logic       viol
);

  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]     PulseLast = 8'(PULSE_CYC - 1);
  localparam logic [7:0]     HoldLast  = 8'(HOLDOFF_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic           sync1_q, sync2_q;
  logic           deb_q, deb_d;
  logic           deb_prev_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     state_q, state_d;
  logic [7:0]     tmr_q, tmr_d;
  logic           trigger;

  // Two-flop synchronizer for the asynchronous stop-line sensor.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= car;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: adopt the synchronized level after DEBOUNCE_CYC consecutive
  // differing cycles; any agreement restarts the run.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DbLast) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounced level, its stability counter and the edge-detect delay flop.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= 1'b0;
      db_cnt_q   <= '0;
      deb_prev_q <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      deb_prev_q <= deb_q;
    end
  end

  // The light is sampled in the same cycle the debounced edge is seen.
  assign trigger = deb_q & ~deb_prev_q & is_red(light);

  // Pulse FSM next state; tmr counts cycles spent in PULSE or HOLDOFF.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          accept  = 1'b1;
          state_d = ST_PULSE;
          tmr_d   = 8'd0;
        end
      end
      ST_PULSE: begin
        if (tmr_q == PulseLast) begin
          state_d = ST_HOLDOFF;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_q == HoldLast) begin
          state_d = ST_IDLE;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = 8'd0;
      end
    endcase
  end

  // FSM state; async reset drops viol at once since viol decodes state_q.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign viol = (state_q == ST_PULSE);

endmodule

// File: rtl/viol_detect.sv
// Red-light violation detector top: four independent channels, the combined
// violation flag and the saturating accepted-violation counter.
module viol_detect
  import viol_detect_pkg::*;
#(
  parameter int unsigned PULSE_CYC    = PULSE_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input logic          clk_50,
  input logic          rst_n,
  viol_detect_if.slave bus
);

  logic [3:0] accept;
  logic [2:0] n_acc;
  logic [8:0] sum;
  logic [7:0] count_q, count_d;

  viol_chan #(
    .PULSE_CYC   (PULSE_CYC),
    .HOLDOFF_CYC (HOLDOFF_CYC),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_chan_n (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .light (bus.light_n),
    .car   (bus.car_n),
    .accept(accept[0]),
    .viol  (bus.viol_n_50)
  );

  viol_chan #(
    .PULSE_CYC   (PULSE_CYC),
    .HOLDOFF_CYC (HOLDOFF_CYC),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_chan_s (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .light (bus.light_s),
    .car   (bus.car_s),
    .accept(accept[1]),
    .viol  (bus.viol_s_50)
  );

  viol_chan #(
    .PULSE_CYC   (PULSE_CYC),
    .HOLDOFF_CYC (HOLDOFF_CYC),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_chan_w (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .light (bus.light_w),
    .car   (bus.car_w),
    .accept(accept[2]),
    .viol  (bus.viol_w_50)
  );

  viol_chan #(
    .PULSE_CYC   (PULSE_CYC),
    .HOLDOFF_CYC (HOLDOFF_CYC),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_chan_e (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .light (bus.light_e),
    .car   (bus.car_e),
    .accept(accept[3]),
    .viol  (bus.viol_e_50)
  );

  assign bus.viol_any = bus.viol_n_50 | bus.viol_s_50 | bus.viol_w_50 | bus.viol_e_50;

  // Add however many channels accepted this cycle; clear wins, top saturates.
  always_comb begin
    n_acc = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n_acc = n_acc + {2'b00, accept[i]};
    end
    sum = {1'b0, count_q} + {6'd0, n_acc};
    if (bus.count_clr) begin
      count_d = 8'd0;
    end else if (sum[8]) begin
      count_d = 8'hFF;
    end else begin
      count_d = sum[7:0];
    end
  end

  // Accepted-violation counter register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.viol_count = count_q;

endmodule

// File: tb/tb_viol_detect.sv
// Self-checking bench for viol_detect with short debounce.
module tb_viol_detect;

  localparam int PULSE = 8;
  localparam int HOLD  = 16;
  localparam int DEB   = 4;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;

  viol_detect_if bus ();

  viol_detect #(
    .PULSE_CYC   (PULSE),
    .HOLDOFF_CYC (HOLD),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state, per channel n,s,w,e.
  int m_s1[4], m_s2[4], m_deb[4], m_prev[4], m_run[4];
  int m_pulse_left[4], m_hold_left[4];
  int m_count = 0;
  int m_acc;
  bit m_trig;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] light_of(input int ch);
    case (ch)
      0: return bus.light_n;
      1: return bus.light_s;
      2: return bus.light_w;
      default: return bus.light_e;
    endcase
  endfunction

  function automatic int car_of(input int ch);
    case (ch)
      0: return int'(bus.car_n);
      1: return int'(bus.car_s);
      2: return int'(bus.car_w);
      default: return int'(bus.car_e);
    endcase
  endfunction

  // ch 0..3 selects a channel, anything else selects viol_any.
  function automatic logic viol_of(input int ch);
    case (ch)
      0: return bus.viol_n_50;
      1: return bus.viol_s_50;
      2: return bus.viol_w_50;
      3: return bus.viol_e_50;
      default: return bus.viol_any;
    endcase
  endfunction

  function automatic logic [3:0] viol_vec();
    return {bus.viol_e_50, bus.viol_w_50, bus.viol_s_50, bus.viol_n_50};
  endfunction

  // Model: advance on each clock edge, clear on reset assertion.
  initial begin
    forever begin
      @(posedge clk_50 or negedge rst_n);
      if (!rst_n) begin
        for (int ch = 0; ch < 4; ch++) begin
          m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0; m_prev[ch] = 0; m_run[ch] = 0;
          m_pulse_left[ch] = 0; m_hold_left[ch] = 0;
        end
        m_count = 0;
      end else begin
        m_acc = 0;
        for (int ch = 0; ch < 4; ch++) begin
          m_trig = (m_deb[ch] == 1) && (m_prev[ch] == 0) &&
                   (light_of(ch) == 2'b00 || light_of(ch) == 2'b11);
          if (m_pulse_left[ch] > 0) begin
            m_pulse_left[ch]--;
            if (m_pulse_left[ch] == 0) m_hold_left[ch] = HOLD;
          end else if (m_hold_left[ch] > 0) begin
            m_hold_left[ch]--;
          end else if (m_trig) begin
            m_pulse_left[ch] = PULSE;
            m_acc++;
          end
          m_prev[ch] = m_deb[ch];
          if (m_s2[ch] != m_deb[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == DEB) begin
              m_deb[ch] = m_s2[ch];
              m_run[ch] = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
          m_s2[ch] = m_s1[ch];
          m_s1[ch] = car_of(ch);
        end
        if (bus.count_clr) m_count = 0;
        else m_count = (m_count + m_acc > 255) ? 255 : m_count + m_acc;
      end
    end
  end

  // Compare DUT against the model every falling edge.
  initial begin
    forever begin
      @(negedge clk_50);
      for (int ch = 0; ch < 4; ch++) begin
        chk($sformatf("model_viol_ch%0d", ch), int'(viol_of(ch)),
            (m_pulse_left[ch] > 0) ? 1 : 0);
      end
      chk("model_viol_any", int'(bus.viol_any),
          ((m_pulse_left[0] + m_pulse_left[1] + m_pulse_left[2] + m_pulse_left[3]) > 0) ? 1 : 0);
      chk("model_count", int'(bus.viol_count), m_count);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic set_cars(input logic [3:0] v);
    bus.car_n = v[0]; bus.car_s = v[1]; bus.car_w = v[2]; bus.car_e = v[3];
  endtask

  // Edges from now until viol_of(ch) is seen high; -1 if never.
  task automatic wait_rise(input int ch, input int max, output int edges);
    edges = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk_50);
      #1;
      if (viol_of(ch)) begin
        edges = i;
        break;
      end
    end
  endtask

  // Called just after a rise was seen; counts cycles the output stays high.
  task automatic high_width(input int ch, output int w);
    w = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_50);
      #1;
      if (viol_of(ch)) w++;
      else break;
    end
  endtask

  // One round of triggers on the selected channels, then settle to IDLE.
  task automatic round(input logic [3:0] v);
    set_cars(v);
    cyc(8);
    set_cars(4'b0000);
    cyc(30);
  endtask

  int lat, w;

  initial begin
    bus.light_n = 2'b00; bus.light_s = 2'b00; bus.light_w = 2'b00; bus.light_e = 2'b00;
    set_cars(4'b0000);
    bus.count_clr = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    chk("reset_viol_vec", int'(viol_vec()), 0);
    chk("reset_count", int'(bus.viol_count), 0);
    rst_n = 1'b1;
    cyc(3);

    // Basic red-light violation on north.
    bus.car_n = 1'b1;
    wait_rise(0, 30, lat);
    chk("latency_n", lat, DEB + 3);
    high_width(0, w);
    chk("pulse_width_n", w, PULSE);
    chk("count_after_first", int'(bus.viol_count), 1);
    @(negedge clk_50);
    bus.car_n = 1'b0;
    cyc(40);

    // Yellow and green never trigger; a short glitch under red is filtered.
    bus.light_n = 2'b10;
    bus.car_n = 1'b1; cyc(15); bus.car_n = 1'b0; cyc(12);
    chk("yellow_no_count", int'(bus.viol_count), 1);
    bus.light_n = 2'b01;
    bus.car_n = 1'b1; cyc(15); bus.car_n = 1'b0; cyc(12);
    chk("green_no_count", int'(bus.viol_count), 1);
    bus.light_n = 2'b00;
    cyc(2);
    bus.car_n = 1'b1; cyc(3); bus.car_n = 1'b0; cyc(15);
    chk("glitch_no_count", int'(bus.viol_count), 1);

    // Toggling sensor: edges at +0,+12,+24,+36,+48; only +0 and +36 land in IDLE.
    for (int k = 0; k < 10; k++) begin
      bus.car_n = (k % 2 == 0) ? 1'b1 : 1'b0;
      cyc(6);
    end
    bus.car_n = 1'b0;
    cyc(40);
    chk("toggle_count", int'(bus.viol_count), 3);

    // All four at once; east uses the reserved encoding which counts as red.
    bus.light_e = 2'b11;
    set_cars(4'b1111);
    wait_rise(4, 30, lat);
    chk("simul_latency", lat, DEB + 3);
    chk("simul_vec", int'(viol_vec()), 15);
    high_width(4, w);
    chk("simul_any_width", w, PULSE);
    chk("simul_count", int'(bus.viol_count), 7);
    @(negedge clk_50);
    set_cars(4'b0000);
    cyc(40);

    // Saturation: clear, preload 254, then push over the top.
    bus.count_clr = 1'b1; cyc(1); bus.count_clr = 1'b0; cyc(1);
    chk("clear_count", int'(bus.viol_count), 0);
    for (int r = 0; r < 63; r++) round(4'b1111);
    round(4'b0011);
    chk("preload_254", int'(bus.viol_count), 254);
    round(4'b1100);
    chk("sat_255", int'(bus.viol_count), 255);
    round(4'b1111);
    chk("sat_hold_255", int'(bus.viol_count), 255);

    // count_clr in the very cycle north accepts a trigger.
    bus.car_n = 1'b1;
    cyc(DEB + 2);
    bus.count_clr = 1'b1;
    cyc(1);
    bus.count_clr = 1'b0;
    chk("clr_priority_count", int'(bus.viol_count), 0);
    chk("clr_priority_viol", int'(bus.viol_n_50), 1);
    cyc(2);
    chk("clr_priority_stays", int'(bus.viol_count), 0);
    bus.car_n = 1'b0;
    cyc(40);

    // Asynchronous reset in the third PULSE cycle, sensor kept high.
    bus.car_n = 1'b1;
    wait_rise(0, 30, lat);
    chk("pre_reset_latency", lat, DEB + 3);
    @(posedge clk_50);
    @(posedge clk_50);
    #3;
    chk("pre_reset_count", int'(bus.viol_count), 1);
    rst_n = 1'b0;
    #1;
    chk("async_drop_viol", int'(bus.viol_n_50), 0);
    chk("async_drop_any", int'(bus.viol_any), 0);
    chk("async_count", int'(bus.viol_count), 0);
    @(negedge clk_50);
    @(negedge clk_50);
    rst_n = 1'b1;
    wait_rise(0, 30, lat);
    chk("retrigger_latency", lat, DEB + 3);
    chk("retrigger_count", int'(bus.viol_count), 1);
    @(negedge clk_50);
    bus.car_n = 1'b0;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/viol_detect.md
VIOL_DETECT -- requirements
Module: viol_detect

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 8: viol_* high width in clk_50 cycles (range 4..255).
REQ-002 SHALL have parameter HOLDOFF_CYC, default 16: per-channel low time after each pulse before re-arm (range 1..255).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 1000000: required sensor stability in clk_50 cycles (range 2..2^20).
REQ-004 SHALL have port clk_50, input, 1 bit: the single 50 MHz clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports light_n, light_s, light_w, light_e, input, 2 bits each, synchronous to clk_50: 00 red, 01 green, 10 yellow, 11 reserved.
REQ-007 SHALL have ports car_n, car_s, car_w, car_e, input, 1 bit each, asynchronous raw stop-line sensors, active-high.
REQ-008 SHALL have port count_clr, input, 1 bit, synchronous clear of viol_count.
REQ-009 SHALL have ports viol_n_50, viol_s_50, viol_w_50, viol_e_50, output, 1 bit each: stretched violation pulses consumed by the pixel-clock flash generator.
REQ-010 SHALL have port viol_any, output, 1 bit: OR of the four viol_*_50 outputs.
REQ-011 SHALL have port viol_count, output, 8 bits: total accepted violations, saturating.

Function
REQ-012 Each car_* SHALL pass through a 2-FF synchronizer, then a debouncer: the debounced state takes the synchronized value only after it has differed from the debounced state for DEBOUNCE_CYC consecutive cycles; any return to equality restarts the count at 0.
REQ-013 A trigger SHALL occur on a debounced 0->1 edge of a channel's sensor in a cycle where that channel's light is 00 (red) or 11 (reserved, treated as red); yellow and green SHALL never trigger.
REQ-014 Each channel SHALL run an FSM IDLE -> PULSE -> HOLDOFF -> IDLE.
REQ-015 In IDLE, a trigger SHALL move the FSM to PULSE and count as accepted.
REQ-016 viol_*_50 SHALL be high exactly PULSE_CYC cycles while the FSM is in PULSE, starting on the clock edge after the trigger cycle.
REQ-017 The FSM SHALL stay in HOLDOFF for exactly HOLDOFF_CYC cycles with viol low.
REQ-018 Triggers in PULSE or HOLDOFF SHALL be ignored and not counted.
REQ-019 Latency from a clean raw car_* rise, with red light, to viol rise SHALL be exactly DEBOUNCE_CYC+3 clk_50 edges.
REQ-020 viol_count SHALL add the number of channels accepting a trigger in that cycle (0..4) and saturate at 255.
REQ-021 count_clr SHALL set viol_count to 0 on the next edge and SHALL take priority over same-cycle increments.
REQ-022 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL each be accepted.
REQ-023 A light change in the same cycle as a debounced edge SHALL use the light value sampled in that cycle.

Reset
REQ-024 While rst_n is low: all synchronizer, debouncer and edge registers SHALL be 0, every FSM SHALL be IDLE, all viol_*_50 and viol_any SHALL be 0, and viol_count SHALL be 0.
REQ-025 Reset asserted mid-PULSE SHALL drop viol immediately, without waiting for a clock edge.
REQ-026 After release, a sensor already high SHALL produce a trigger only after debounce and only if the light is red.

Structure
REQ-027 Light encodings (RED, GREEN, YELLOW, RSVD) and the default PULSE_CYC, HOLDOFF_CYC and DEBOUNCE_CYC values SHALL live in the shared traffic package.
REQ-028 One sub-module, viol_chan, SHALL hold the synchronizer, debouncer, edge detect and FSM for one channel and SHALL be instantiated four times.
REQ-029 The top level SHALL hold only the counter and viol_any.

Verification (DEBOUNCE_CYC=4, PULSE_CYC=8, HOLDOFF_CYC=16)
REQ-030 light_n=00; car_n rises and holds -> viol_n_50 rises 7 edges later and stays high 8 cycles; viol_count=1.
REQ-031 light_n=10 or 01; car_n rises -> no viol_n_50 and viol_count unchanged; car_n glitch high 3 cycles under red -> no trigger.
REQ-032 Under red, car_n toggles 0/1 with 6 cycles per level for 60 cycles -> one pulse per 24-cycle window and viol_count equals accepted pulses only.
REQ-033 All four channels red and cars rise in the same cycle -> four simultaneous pulses, viol_any high 8 cycles, viol_count += 4.
REQ-034 viol_count preloaded to 254 by repeated triggers, then 2 simultaneous triggers -> 255; further triggers -> 255; count_clr with a same-cycle trigger -> 0.
REQ-035 rst_n low for 1 cycle at PULSE cycle 3 -> viol drops asynchronously, FSM IDLE, viol_count=0; a car held high re-triggers after debounce under red.
